seq_eval_ctrl: RTL and testbench
================================

Name: seq_eval_ctrl

Overview:
- Fitness-evaluation sequencer for a candidate serial sequence detector (1-bit input `i`, registered 1-bit output `out`).
- Holds a programmable stimulus/expected-output vector table and drives the detector's `rst` and `i`.
- Samples `out` with a fixed latency, compares it to the expected bit, and reports a match score.
- Sits between the candidate detector and the host that programs patterns and collects scores.

Parameters:
- DEPTH, 64, vector table entries (power of 2, ≥2).
- DUT_LAT, 1, cycles from dut_i presentation to the corresponding dut_out (1..4).
- RST_CYCLES, 2, cycles dut_rst is held before a run (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  table write strobe; honoured only when busy=0
- cfg_addr  in  $clog2(DEPTH)  table write address
- cfg_stim  in  1  stimulus bit for entry
- cfg_exp  in  1  expected detector output for entry
- cfg_len  in  $clog2(DEPTH)+1  vectors per run; sampled at start
- start  in  1  run request; honoured only when busy=0
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- dut_rst  out  1  reset to detector
- dut_i  out  1  serial input to detector
- dut_out  in  1  detector output
- score  out  $clog2(DEPTH)+1  matching vectors in last run
- mismatches  out  $clog2(DEPTH)+1  failing vectors in last run
- fail_seen  out  1  at least one mismatch in last run
- first_fail  out  $clog2(DEPTH)  index of first mismatch; 0 if none

Behaviour:
- Reset values:
  - State IDLE; busy=0, done=0, dut_rst=1, dut_i=0.
  - score=0, mismatches=0, fail_seen=0, first_fail=0.
  - Pipeline valid bits cleared.
  - Table contents are not reset.
- All outputs are registered.
- FSM IDLE -> RESET -> DRIVE -> DRAIN -> FINISH -> IDLE:
  - IDLE: dut_rst=1, dut_i=0.
    - On start: latch len = min(cfg_len, DEPTH).
    - Clear score, mismatches, fail_seen and first_fail.
    - Set busy=1 and go to RESET.
  - RESET: dut_rst=1 for exactly RST_CYCLES cycles, then DRIVE with index k=0.
    - If len==0, go directly to FINISH.
  - DRIVE: dut_rst=0, dut_i=stim[k] for one cycle per vector.
    - Push (exp[k], k, valid=1) into a DUT_LAT-deep delay line.
    - After k=len-1, go to DRAIN.
  - DRAIN: dut_rst=0, dut_i=0.
    - Stay DUT_LAT cycles until the delay line empties.
  - FINISH: done=1 for one cycle, busy=0, then IDLE.
- Compare: each cycle the delay-line head is valid, dut_out==exp increments score; otherwise:
  - Increment mismatches.
  - If fail_seen=0, set fail_seen=1 and first_fail=k.
- Invariant: score+mismatches==len at done.
- Vector k presented in cycle t is compared against dut_out in cycle t+DUT_LAT.
- Table is a 2-bit × DEPTH array: synchronous write, combinational read.
- Boundary rules:
  - start while busy: ignored.
  - cfg_we while busy: ignored; table unchanged.
  - cfg_we and start in the same IDLE cycle: the write takes effect, then the run starts; the written entry is visible from RESET onward.
  - cfg_len > DEPTH: clamped to DEPTH.
  - cfg_len==0: run completes with done, score=0.
  - Counters cannot overflow because they are width $clog2(DEPTH)+1.
  - rst mid-run: immediate return to reset values; dut_rst=1 from the next cycle; the pending compare pipeline is discarded.
  - Results hold until the next accepted start.

Decomposition:
- Package seq_eval_pkg:
  - State enum (IDLE, RESET, DRIVE, DRAIN, FINISH).
  - Default parameter constants.
  - Index/count width typedefs derived from DEPTH.
- Sub-module seq_eval_table: 2-bit-wide vector RAM with write port and combinational read port.
- FSM, delay line and scoring stay in seq_eval_ctrl.

Test Plan:
- Reference-model DUT = "10" detector (out registered, DUT_LAT=1); stim 1,0,1,0,0,1,0; exp 0,1,0,1,0,0,1; len=7, start -> dut_rst high 2 cycles, done after 2+7+1 cycles, score=7, mismatches=0, fail_seen=0.
- Same stimulus, exp[3] flipped to 0 -> score=6, mismatches=1, fail_seen=1, first_fail=3.
- cfg_len=0, start -> busy for RESET only, done pulse, score=0, mismatches=0.
- cfg_len=100 with DEPTH=64, all stim 1, DUT out stuck 0, all exp 0 -> score=64.
- start and cfg_we (addr 0, stim 1) while busy -> both ignored; rerun gives an identical score. rst asserted mid-DRIVE -> busy=0, dut_rst=1 next cycle, no done pulse, score=0.
- DUT_LAT=3 with an equivalently delayed model -> same scores as DUT_LAT=1; DRAIN lasts 3 cycles.

Source files
------------

// File: rtl/seq_eval_pkg.sv
// rtl/seq_eval_pkg.sv - shared constants, state encoding and width types for the evaluation sequencer
package seq_eval_pkg;

  // Default build: 64-entry table, single-cycle detector, two reset cycles.
  localparam int DEF_DEPTH      = 64;
  localparam int DEF_DUT_LAT    = 1;
  localparam int DEF_RST_CYCLES = 2;

  // Index and count widths for the default depth; counts need one extra bit to hold DEPTH itself.
  localparam int DEF_IDX_W = $clog2(DEF_DEPTH);
  localparam int DEF_CNT_W = DEF_IDX_W + 1;

  typedef logic [DEF_IDX_W-1:0] idx_t;
  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // Sequencer states.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RESET  = 3'd1;
  localparam state_t ST_DRIVE  = 3'd2;
  localparam state_t ST_DRAIN  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;

  // Used to size the shared RESET/DRAIN cycle counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_eval_table.sv
// rtl/seq_eval_table.sv - 2-bit x DEPTH stimulus/expected vector RAM, sync write, async read
module seq_eval_table
  import seq_eval_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [1:0]               wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [1:0]               rdata_o
);

  // Bit 1 holds the stimulus, bit 0 the expected detector output.
  logic [1:0] mem_q [DEPTH];

  // Write port: contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/seq_eval_ctrl.sv
// rtl/seq_eval_ctrl.sv - drives a candidate sequence detector from a vector table and scores its output
module seq_eval_ctrl
  import seq_eval_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DUT_LAT    = DEF_DUT_LAT,
  parameter int RST_CYCLES = DEF_RST_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic                     cfg_stim,
  input  logic                     cfg_exp,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     dut_rst,
  output logic                     dut_i,
  input  logic                     dut_out,
  output logic [$clog2(DEPTH):0]   score,
  output logic [$clog2(DEPTH):0]   mismatches,
  output logic                     fail_seen,
  output logic [$clog2(DEPTH)-1:0] first_fail
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int CT_W  = $clog2(max_int(RST_CYCLES, DUT_LAT) + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CT_W-1:0]  RST_LAST = CT_W'(RST_CYCLES - 1);
  localparam logic [CT_W-1:0]  LAT_LAST = CT_W'(DUT_LAT - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CT_W-1:0]    cnt_q, cnt_d;

  logic               busy_q, done_q, dut_rst_q, dut_i_q;
  // Expected bit travelling alongside the vector currently on dut_i.
  logic               exp_cur_q;

  logic [CNT_W-1:0]   score_q, mism_q;
  logic               fail_q;
  logic [IDX_W-1:0]   ff_q;

  // Compare delay line; stage DUT_LAT-1 lines up with dut_out for the same vector.
  logic [DUT_LAT-1:0]            pv_q;
  logic [DUT_LAT-1:0]            pe_q;
  logic [DUT_LAT-1:0][IDX_W-1:0] pk_q;

  logic [1:0] rd_data;
  logic       tbl_we;
  logic       accept;
  logic       last_vec;

  assign tbl_we   = cfg_we & ~busy_q;
  assign accept   = (state_q == ST_IDLE) & start;
  assign last_vec = ({1'b0, k_q} == (len_q - 1'b1));

  // Read address is the next index so the registered dut_i carries stim[k] in the DRIVE cycle for k.
  seq_eval_table #(
    .DEPTH(DEPTH)
  ) u_table (
    .clk_i  (clk),
    .we_i   (tbl_we),
    .waddr_i(cfg_addr),
    .wdata_i({cfg_stim, cfg_exp}),
    .raddr_i(k_d),
    .rdata_o(rd_data)
  );

  // Next-state logic for the run sequence and its counters.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = (cfg_len > DEPTH_C) ? DEPTH_C : cfg_len;
          cnt_d   = '0;
          k_d     = '0;
          state_d = ST_RESET;
        end
      end
      ST_RESET: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          k_d     = '0;
          state_d = (len_q == '0) ? ST_FINISH : ST_DRIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (last_vec) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == LAT_LAST) begin
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, counters and control outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dut_rst_q <= 1'b1;
      dut_i_q   <= 1'b0;
      exp_cur_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      busy_q    <= (state_d == ST_RESET) | (state_d == ST_DRIVE) | (state_d == ST_DRAIN);
      done_q    <= (state_d == ST_FINISH);
      dut_rst_q <= (state_d == ST_IDLE) | (state_d == ST_RESET) | (state_d == ST_FINISH);
      dut_i_q   <= (state_d == ST_DRIVE) & rd_data[1];
      exp_cur_q <= rd_data[0];
    end
  end

  // Delay line shifts every cycle and is loaded while a vector is on dut_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pe_q <= '0;
      pk_q <= '0;
    end else begin
      pv_q[0] <= (state_q == ST_DRIVE);
      pe_q[0] <= exp_cur_q;
      pk_q[0] <= k_q;
      for (int i = 1; i < DUT_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pk_q[i] <= pk_q[i-1];
      end
    end
  end

  // Scoring of the delay-line head against the detector; results persist until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= '0;
      mism_q  <= '0;
      fail_q  <= 1'b0;
      ff_q    <= '0;
    end else if (accept) begin
      score_q <= '0;
      mism_q  <= '0;
      fail_q  <= 1'b0;
      ff_q    <= '0;
    end else if (pv_q[DUT_LAT-1]) begin
      if (dut_out == pe_q[DUT_LAT-1]) begin
        score_q <= score_q + 1'b1;
      end else begin
        mism_q <= mism_q + 1'b1;
        if (!fail_q) begin
          fail_q <= 1'b1;
          ff_q   <= pk_q[DUT_LAT-1];
        end
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dut_rst    = dut_rst_q;
  assign dut_i      = dut_i_q;
  assign score      = score_q;
  assign mismatches = mism_q;
  assign fail_seen  = fail_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_seq_eval_ctrl.sv
// tb/tb_seq_eval_ctrl.sv - self-checking bench for seq_eval_ctrl with "10" detectors at latency 1 and 3
module tb_seq_eval_ctrl;

  localparam int DEPTH = 64;
  localparam int RST   = 2;
  localparam int IW    = 6;
  localparam int CW    = 7;

  logic clk = 1'b0;
  logic rst, cfg_we, cfg_stim, cfg_exp, start;
  logic [IW-1:0] cfg_addr;
  logic [CW-1:0] cfg_len;

  logic busy1, done1, drst1, di1, dout1, fs1;
  logic [CW-1:0] sc1, mm1;
  logic [IW-1:0] ff1;
  logic busy3, done3, drst3, di3, dout3, fs3;
  logic [CW-1:0] sc3, mm3;
  logic [IW-1:0] ff3;

  int checks = 0;
  int errors = 0;
  bit stuck = 1'b0;
  bit m_stim [DEPTH];
  bit m_exp  [DEPTH];

  logic p1, o1, p3, r3, q3a, q3b;

  always #5 clk = ~clk;

  seq_eval_ctrl #(.DEPTH(DEPTH), .DUT_LAT(1), .RST_CYCLES(RST)) u1 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_stim(cfg_stim),
    .cfg_exp(cfg_exp), .cfg_len(cfg_len), .start(start), .busy(busy1), .done(done1),
    .dut_rst(drst1), .dut_i(di1), .dut_out(dout1), .score(sc1), .mismatches(mm1),
    .fail_seen(fs1), .first_fail(ff1)
  );

  seq_eval_ctrl #(.DEPTH(DEPTH), .DUT_LAT(3), .RST_CYCLES(RST)) u3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_stim(cfg_stim),
    .cfg_exp(cfg_exp), .cfg_len(cfg_len), .start(start), .busy(busy3), .done(done3),
    .dut_rst(drst3), .dut_i(di3), .dut_out(dout3), .score(sc3), .mismatches(mm3),
    .fail_seen(fs3), .first_fail(ff3)
  );

  // Candidate "10" detector with registered output (latency 1); stuck forces output 0.
  always_ff @(posedge clk) begin
    if (drst1) begin
      p1 <= 1'b0;
      o1 <= 1'b0;
    end else begin
      p1 <= di1;
      o1 <= !stuck && p1 && !di1;
    end
  end
  assign dout1 = o1;

  // Same detector followed by two extra register stages (latency 3).
  always_ff @(posedge clk) begin
    if (drst3) begin
      p3  <= 1'b0;
      r3  <= 1'b0;
      q3a <= 1'b0;
      q3b <= 1'b0;
    end else begin
      p3  <= di3;
      r3  <= !stuck && p3 && !di3;
      q3a <= r3;
      q3b <= q3a;
    end
  end
  assign dout3 = q3b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wr(input int a, input bit s, input bit e);
    cfg_we = 1'b1;
    cfg_addr = IW'(a);
    cfg_stim = s;
    cfg_exp = e;
    m_stim[a] = s;
    m_exp[a] = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Reference: walk the first len vectors through an ideal "10" detector and tally agreement.
  task automatic model(input int len, output int sc, output int mm, output int fs, output int ff);
    bit prev;
    bit det;
    sc = 0; mm = 0; fs = 0; ff = 0; prev = 1'b0;
    for (int k = 0; k < len; k++) begin
      det = !stuck && prev && !m_stim[k];
      prev = m_stim[k];
      if (det == m_exp[k]) sc++;
      else begin
        mm++;
        if (fs == 0) begin fs = 1; ff = k; end
      end
    end
  endtask

  task automatic fill_random();
    bit prev;
    bit s;
    bit e;
    prev = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      s = 1'($urandom_range(0, 1));
      e = prev && !s;
      if ($urandom_range(0, 3) == 0) e = !e;
      prev = s;
      wr(a, s, e);
    end
  endtask

  // mode 0: plain run; 1: start/cfg_we pulsed mid-run; 2: table write in the start cycle.
  task automatic do_run(input string tag, input int cl, input int mode, input int wa, input bit ws, input bit wx);
    int len, sc, mm, fs, ff, t, d1, d3, rsth, ki, di_bad;
    cfg_len = CW'(cl);
    start = 1'b1;
    if (mode == 2) begin
      cfg_we = 1'b1; cfg_addr = IW'(wa); cfg_stim = ws; cfg_exp = wx;
      m_stim[wa] = ws; m_exp[wa] = wx;
    end
    @(negedge clk);
    start = 1'b0;
    cfg_we = 1'b0;
    len = (cl > DEPTH) ? DEPTH : cl;
    model(len, sc, mm, fs, ff);
    t = 1; d1 = -1; d3 = -1; rsth = 0; ki = 0; di_bad = 0;
    while ((d1 < 0 || d3 < 0) && t < 300) begin
      if (busy1 && drst1) rsth++;
      if (busy1 && !drst1) begin
        if (di1 !== ((ki < len) ? m_stim[ki] : 1'b0)) di_bad++;
        ki++;
      end
      if (done1 && d1 < 0) d1 = t;
      if (done3 && d3 < 0) d3 = t;
      if (mode == 1 && t == RST + 2) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = '0;
        cfg_stim = !m_stim[0]; cfg_exp = !m_exp[0];
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    cfg_we = 1'b0;
    chk({tag, " done cycle lat1"}, d1, (len == 0) ? RST + 1 : RST + len + 2);
    chk({tag, " done cycle lat3"}, d3, (len == 0) ? RST + 1 : RST + len + 4);
    chk({tag, " dut_rst cycles"}, rsth, RST);
    chk({tag, " dut_i stream"}, di_bad, 0);
    chk({tag, " busy after"}, 32'(busy1), 0);
    chk({tag, " score lat1"}, 32'(sc1), sc);
    chk({tag, " mism lat1"}, 32'(mm1), mm);
    chk({tag, " fail lat1"}, 32'(fs1), fs);
    chk({tag, " first lat1"}, 32'(ff1), ff);
    chk({tag, " score lat3"}, 32'(sc3), sc);
    chk({tag, " mism lat3"}, 32'(mm3), mm);
    chk({tag, " fail lat3"}, 32'(fs3), fs);
    chk({tag, " first lat3"}, 32'(ff3), ff);
  endtask

  initial begin
    int ds [7];
    int de [7];
    int saw;
    ds = '{1, 0, 1, 0, 0, 1, 0};
    de = '{0, 1, 0, 1, 0, 0, 1};
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_stim = 1'b0; cfg_exp = 1'b0;
    cfg_len = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy1), 0);
    chk("reset done", 32'(done1), 0);
    chk("reset dut_rst", 32'(drst1), 1);
    chk("reset dut_i", 32'(di1), 0);
    chk("reset score", 32'(sc1), 0);
    chk("reset mism", 32'(mm1), 0);
    chk("reset fail", 32'(fs1), 0);
    chk("reset first", 32'(ff1), 0);
    chk("reset busy lat3", 32'(busy3), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) wr(i, ds[i][0], de[i][0]);
    do_run("base", 7, 0, 0, 1'b0, 1'b0);
    chk("base plan score", 32'(sc1), 7);

    wr(3, 1'b0, 1'b0);
    do_run("flip3", 7, 0, 0, 1'b0, 1'b0);
    chk("flip3 plan score", 32'(sc1), 6);
    chk("flip3 plan first", 32'(ff1), 3);

    do_run("len0", 0, 0, 0, 1'b0, 1'b0);

    stuck = 1'b1;
    for (int i = 0; i < DEPTH; i++) wr(i, 1'b1, 1'b0);
    do_run("clamp", 100, 0, 0, 1'b0, 1'b0);
    chk("clamp plan score", 32'(sc1), 64);
    stuck = 1'b0;

    fill_random();
    do_run("pre-busy", 7, 0, 0, 1'b0, 1'b0);
    do_run("busy-ignore", 7, 1, 0, 1'b0, 1'b0);
    do_run("post-busy", 7, 0, 0, 1'b0, 1'b0);
    do_run("we+start", 5, 2, 0, !m_stim[0], !m_exp[0]);

    cfg_len = 7'd20;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst busy before", 32'(busy1), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 32'(busy1), 0);
    chk("midrst dut_rst", 32'(drst1), 1);
    chk("midrst done", 32'(done1), 0);
    chk("midrst score", 32'(sc1), 0);
    chk("midrst mism", 32'(mm1), 0);
    chk("midrst busy lat3", 32'(busy3), 0);
    saw = 0;
    repeat (40) begin
      @(negedge clk);
      if (done1 || done3 || busy1 || busy3) saw = 1;
    end
    chk("midrst quiet", saw, 0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      do_run("random", $urandom_range(0, 72), 0, 0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
